// File: rtl/armleocpu_alu_arbiter.sv
// armleocpu_alu_arbiter
//   Shares one armleocpu_alu between two requesters (0 = execute stage,
//   1 = auxiliary unit). Requests are arbitrated round-robin and the chosen
//   lane drives the ALU. The result is registered and returned on a
//   per-requester valid/ready response port. One operation is in flight at a
//   time. When responses are consumed immediately, throughput is 1 op/cycle.
//
// Ports (lane i of each vector belongs to requester i):
//   clk, rst          clock; asynchronous active-high reset
//   req_valid/ready   request handshake, 2 lanes (req_ready is combinational)
//   req_is_op         R-type op          req_is_op_imm  I-type op
//   req_shamt         5b per lane        req_funct7     7b per lane
//   req_funct3        3b per lane
//   req_rs1/rs2       32b per lane       req_simm12     32b per lane
//   rsp_valid/ready   response handshake, 2 lanes
//   rsp_result        registered ALU result (shared, qualified by rsp_valid)
//   rsp_illegal       registered ALU illegal_instruction flag
//
// state | meaning
// IDLE  | no response held
// RESP  | response held for requester `owner`
module armleocpu_alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_is_op,
  input  logic [1:0]  req_is_op_imm,
  input  logic [9:0]  req_shamt,
  input  logic [13:0] req_funct7,
  input  logic [5:0]  req_funct3,
  input  logic [63:0] req_rs1,
  input  logic [63:0] req_rs2,
  input  logic [63:0] req_simm12,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_illegal
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t state, state_next;
  logic   owner, last_grant;
  logic   grant, accept, rsp_hs, can_accept;

  logic        alu_is_op, alu_is_op_imm;
  logic [4:0]  alu_shamt;
  logic [6:0]  alu_funct7;
  logic [2:0]  alu_funct3;
  logic [31:0] alu_rs1, alu_rs2, alu_simm12, alu_result;
  logic        alu_illegal;

  always_comb begin
    state_next = state;
    rsp_hs     = (state == RESP) && rsp_ready[owner];
    // Gating with rst keeps requests presented during reset from being
    // acknowledged even though the registers are held asynchronously.
    can_accept = !rst && ((state == IDLE) || rsp_hs);
    // Tie goes to the lane that did not win last; otherwise the lone valid
    // lane. With nothing valid grant stays 0, which also selects lane 0 for
    // the ALU mux.
    if (req_valid == 2'b11) grant = ~last_grant;
    else                    grant = req_valid[1];
    req_ready = 2'b00;
    if (can_accept && req_valid[grant]) req_ready = grant ? 2'b10 : 2'b01;
    accept = |req_ready;
    if (accept)      state_next = RESP;
    else if (rsp_hs) state_next = IDLE;
  end

  always_comb begin
    alu_is_op     = grant ? req_is_op[1]        : req_is_op[0];
    alu_is_op_imm = grant ? req_is_op_imm[1]    : req_is_op_imm[0];
    alu_shamt     = grant ? req_shamt[9:5]      : req_shamt[4:0];
    alu_funct7    = grant ? req_funct7[13:7]    : req_funct7[6:0];
    alu_funct3    = grant ? req_funct3[5:3]     : req_funct3[2:0];
    alu_rs1       = grant ? req_rs1[63:32]      : req_rs1[31:0];
    alu_rs2       = grant ? req_rs2[63:32]      : req_rs2[31:0];
    alu_simm12    = grant ? req_simm12[63:32]   : req_simm12[31:0];
  end

  armleocpu_alu u_alu (
    .is_op               (alu_is_op),
    .is_op_imm           (alu_is_op_imm),
    .shamt               (alu_shamt),
    .funct7              (alu_funct7),
    .funct3              (alu_funct3),
    .rs1                 (alu_rs1),
    .rs2                 (alu_rs2),
    .simm12              (alu_simm12),
    .result              (alu_result),
    .illegal_instruction (alu_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      rsp_result  <= 32'd0;
      rsp_illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        rsp_result  <= alu_result;
        rsp_illegal <= alu_illegal;
        owner       <= grant;
        last_grant  <= grant;
      end
    end
  end

  assign rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// armleocpu_alu
//   RV32I integer ALU for OP / OP-IMM instructions. Register shifts use
//   rs2[4:0]; immediate shifts use shamt. Undefined encodings raise
//   illegal_instruction and return rs1 + (is_op ? rs2 : simm12).
//
// Ports:
//   is_op, is_op_imm, shamt, funct7, funct3, rs1, rs2, simm12  decoded operands
//   result, illegal_instruction                                combinational outputs
module armleocpu_alu (
  input  logic        is_op,
  input  logic        is_op_imm,
  input  logic [4:0]  shamt,
  input  logic [6:0]  funct7,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] simm12,
  output logic [31:0] result,
  output logic        illegal_instruction
);

  logic [31:0] op2;
  logic [4:0]  sh;
  logic        f7_zero, f7_alt, reg_bad;

  always_comb begin
    op2                 = is_op ? rs2 : simm12;
    sh                  = is_op ? rs2[4:0] : shamt;
    f7_zero             = (funct7 == 7'h00);
    f7_alt              = (funct7 == 7'h20);
    // For non-shift OP encodings, funct7 must be zero. For OP-IMM, those
    // bits are part of the immediate and are not checked.
    reg_bad             = is_op && !f7_zero;
    result              = rs1 + op2;
    illegal_instruction = 1'b0;
    if (is_op || is_op_imm) begin
      case (funct3)
        3'b000: begin
          if (is_op && f7_alt) result = rs1 - rs2;
          else if (reg_bad)    illegal_instruction = 1'b1;
        end
        3'b001: begin
          if (f7_zero) result = rs1 << sh;
          else         illegal_instruction = 1'b1;
        end
        3'b010: begin
          if (reg_bad) illegal_instruction = 1'b1;
          else         result = {31'd0, $signed(rs1) < $signed(op2)};
        end
        3'b011: begin
          if (reg_bad) illegal_instruction = 1'b1;
          else         result = {31'd0, rs1 < op2};
        end
        3'b100: begin
          if (reg_bad) illegal_instruction = 1'b1;
          else         result = rs1 ^ op2;
        end
        3'b101: begin
          if (f7_zero)     result = rs1 >> sh;
          else if (f7_alt) result = $signed(rs1) >>> sh;
          else             illegal_instruction = 1'b1;
        end
        3'b110: begin
          if (reg_bad) illegal_instruction = 1'b1;
          else         result = rs1 | op2;
        end
        default: begin
          if (reg_bad) illegal_instruction = 1'b1;
          else         result = rs1 & op2;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_armleocpu_alu_arbiter.sv
module tb_armleocpu_alu_arbiter;

  typedef struct {
    logic        is_op;
    logic        is_op_imm;
    logic [4:0]  shamt;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] simm12;
    logic [31:0] exp_result;
    logic        exp_illegal;
  } op_t;

  typedef struct {
    logic [1:0]  lane_oh;
    logic [31:0] result;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_illegal;
  op_t         cur [2];

  logic [1:0]  req_is_op, req_is_op_imm;
  logic [9:0]  req_shamt;
  logic [13:0] req_funct7;
  logic [5:0]  req_funct3;
  logic [63:0] req_rs1, req_rs2, req_simm12;

  assign req_is_op     = {cur[1].is_op, cur[0].is_op};
  assign req_is_op_imm = {cur[1].is_op_imm, cur[0].is_op_imm};
  assign req_shamt     = {cur[1].shamt, cur[0].shamt};
  assign req_funct7    = {cur[1].funct7, cur[0].funct7};
  assign req_funct3    = {cur[1].funct3, cur[0].funct3};
  assign req_rs1       = {cur[1].rs1, cur[0].rs1};
  assign req_rs2       = {cur[1].rs2, cur[0].rs2};
  assign req_simm12    = {cur[1].simm12, cur[0].simm12};

  always #5 clk = ~clk;

  armleocpu_alu_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_is_op     (req_is_op),
    .req_is_op_imm (req_is_op_imm),
    .req_shamt     (req_shamt),
    .req_funct7    (req_funct7),
    .req_funct3    (req_funct3),
    .req_rs1       (req_rs1),
    .req_rs2       (req_rs2),
    .req_simm12    (req_simm12),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_illegal   (rsp_illegal)
  );

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sbq[$];
  op_t  cq0[$], cq1[$];
  op_t  tbl [20];

  function automatic op_t mk(input logic io, input logic ii, input logic [4:0] sh,
                             input logic [6:0] f7, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] im, input logic [31:0] r, input logic il);
    op_t o;
    o.is_op = io; o.is_op_imm = ii; o.shamt = sh; o.funct7 = f7; o.funct3 = f3;
    o.rs1 = a; o.rs2 = b; o.simm12 = im; o.exp_result = r; o.exp_illegal = il;
    return o;
  endfunction

  function automatic logic [1:0] oh(input int l);
    return (l == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Negative-edge sample point: scoreboard check of any held response.
  task automatic neg();
    @(negedge clk);
    if (!rst) begin
      if (rsp_valid != 2'b00) begin
        if (sbq.size() == 0) chk("rsp_unexpected", {30'd0, rsp_valid}, 32'd0);
        else begin
          chk("rsp_owner", {30'd0, rsp_valid}, {30'd0, sbq[0].lane_oh});
          chk("rsp_result", rsp_result, sbq[0].result);
          chk("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, sbq[0].illegal});
          if ((rsp_valid & rsp_ready) != 2'b00) sbq.delete(0);
        end
      end
      chk("ready_without_valid", {30'd0, req_ready & ~req_valid}, 32'd0);
    end
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_lane(input int l, input op_t o);
    exp_t e;
    cur[l] = o;
    req_valid[l] = 1'b1;
    e.lane_oh = oh(l); e.result = o.exp_result; e.illegal = o.exp_illegal;
    sbq.push_back(e);
  endtask

  task automatic single(input int l, input op_t o);
    int t;
    t = 0;
    drive_lane(l, o);
    neg();
    while (!req_ready[l] && t < 20) begin
      pos(); neg(); t++;
    end
    chk("accept", {31'd0, req_ready[l]}, 32'd1);
    pos();
    req_valid[l] = 1'b0;
  endtask

  // Both lanes kept valid; the grant must alternate starting with lane 0.
  task automatic contend(input int n_total);
    int         exp_lane, prev, acc, t;
    logic [1:0] got;
    exp_lane = 0; prev = 0; acc = 0; t = 0;
    drive_lane(0, cq0.pop_front());
    drive_lane(1, cq1.pop_front());
    while (acc < n_total && t < 100) begin
      neg();
      t++;
      got = req_ready;
      if (acc > 0) chk("contend_rsp_cont", {30'd0, rsp_valid}, {30'd0, oh(prev)});
      chk("contend_grant", {30'd0, got}, {30'd0, oh(exp_lane)});
      pos();
      if (got[exp_lane]) begin
        acc++;
        req_valid[exp_lane] = 1'b0;
        if (exp_lane == 0 && cq0.size() > 0) drive_lane(0, cq0.pop_front());
        if (exp_lane == 1 && cq1.size() > 0) drive_lane(1, cq1.pop_front());
        prev = exp_lane;
        exp_lane = 1 - exp_lane;
      end
    end
    if (acc < n_total) chk("contend_timeout", acc, n_total);
  endtask

  initial begin
    op_t o;
    logic [31:0] a, b;

    tbl[0]  = mk(1, 0, 0, 7'h00, 3'd0, 32'd5, 32'd7, 0, 32'd12, 0);
    tbl[1]  = mk(1, 0, 0, 7'h20, 3'd0, 32'd5, 32'd7, 0, 32'hFFFF_FFFE, 0);
    tbl[2]  = mk(0, 1, 0, 7'h00, 3'd0, 32'd1, 0, 32'hFFFF_FFFF, 32'd0, 0);
    tbl[3]  = mk(1, 0, 0, 7'h00, 3'd2, 32'hFFFF_FFFF, 32'd1, 0, 32'd1, 0);
    tbl[4]  = mk(1, 0, 0, 7'h00, 3'd3, 32'hFFFF_FFFF, 32'd1, 0, 32'd0, 0);
    tbl[5]  = mk(0, 1, 0, 7'h00, 3'd2, 32'd5, 0, 32'hFFFF_F800, 32'd0, 0);
    tbl[6]  = mk(0, 1, 0, 7'h00, 3'd3, 32'd5, 0, 32'hFFFF_F800, 32'd1, 0);
    tbl[7]  = mk(1, 0, 0, 7'h00, 3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'h0FF0_0FF0, 0);
    tbl[8]  = mk(1, 0, 0, 7'h00, 3'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'hFFF0_FFF0, 0);
    tbl[9]  = mk(1, 0, 0, 7'h00, 3'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'hF000_F000, 0);
    tbl[10] = mk(0, 1, 0, 7'h00, 3'd6, 32'h1234_0000, 0, 32'h0000_0ABC, 32'h1234_0ABC, 0);
    tbl[11] = mk(1, 0, 0, 7'h00, 3'd1, 32'd1, 32'h3F, 0, 32'h8000_0000, 0);
    tbl[12] = mk(1, 0, 0, 7'h00, 3'd5, 32'h8000_0000, 32'd4, 0, 32'h0800_0000, 0);
    tbl[13] = mk(1, 0, 0, 7'h20, 3'd5, 32'h8000_0000, 32'd4, 0, 32'hF800_0000, 0);
    tbl[14] = mk(0, 1, 5'd4, 7'h00, 3'd1, 32'd3, 0, 32'd4, 32'h30, 0);
    tbl[15] = mk(0, 1, 5'd28, 7'h00, 3'd5, 32'hF000_0000, 0, 32'd28, 32'hF, 0);
    tbl[16] = mk(0, 1, 5'd4, 7'h20, 3'd5, 32'h8000_0000, 0, 32'h404, 32'hF800_0000, 0);
    tbl[17] = mk(0, 1, 5'd0, 7'h20, 3'd1, 32'd3, 0, 32'h10, 32'h13, 1);
    tbl[18] = mk(0, 1, 0, 7'h7F, 3'd4, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 32'd0, 0);
    tbl[19] = mk(0, 1, 0, 7'h00, 3'd7, 32'h1234, 0, 32'hFF, 32'h34, 0);

    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    cur[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cur[1] = cur[0];

    // Reset state; requests present during reset must not be accepted.
    #1 req_valid = 2'b11;
    neg();
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_illegal", {31'd0, rsp_illegal}, 32'd0);
    pos();
    req_valid = 2'b00;
    rst = 1'b0;

    // Tie right after reset: lane 0 first, then lane 1.
    rsp_ready = 2'b11;
    cq0.push_back(mk(0, 1, 0, 0, 3'd0, 32'd1, 0, 32'd1, 32'd2, 0));
    cq1.push_back(mk(0, 1, 0, 0, 3'd0, 32'd10, 0, 32'hFFFF_FFFF, 32'd9, 0));
    contend(2);

    // Table of single operations, alternating lanes, issued back to back.
    for (int i = 0; i < 20; i++) single(i % 2, tbl[i]);
    neg();
    pos();

    // Backpressure on lane 1; rsp_ready on non-owner lane 0 is ignored.
    rsp_ready = 2'b01;
    drive_lane(1, mk(0, 1, 5'd4, 7'h20, 3'd5, 32'h8000_0000, 0, 32'h404, 32'hF800_0000, 0));
    neg();
    chk("bp_accept1", {30'd0, req_ready}, 32'b10);
    pos();
    req_valid[1] = 1'b0;
    drive_lane(0, mk(1, 0, 0, 0, 3'd0, 32'h11, 32'h22, 0, 32'h33, 0));
    for (int k = 0; k < 3; k++) begin
      neg();
      chk("bp_ready_blocked", {30'd0, req_ready}, 32'd0);
      chk("bp_rsp_valid", {30'd0, rsp_valid}, 32'b10);
      chk("bp_result_hold", rsp_result, 32'hF800_0000);
      pos();
    end
    rsp_ready = 2'b11;
    neg();
    chk("bp_release_accept0", {30'd0, req_ready}, 32'b01);
    pos();
    req_valid[0] = 1'b0;
    neg();
    pos();

    // Illegal op completes normally; result holds after the handshake.
    single(0, mk(1, 0, 0, 7'h01, 3'd0, 32'd3, 32'd4, 0, 32'd7, 1));
    neg();
    chk("illegal_flag", {31'd0, rsp_illegal}, 32'd1);
    chk("illegal_result", rsp_result, 32'd7);
    pos();
    neg();
    chk("idle_after_hs", {30'd0, rsp_valid}, 32'd0);
    chk("result_hold_idle", rsp_result, 32'd7);
    pos();

    // Reset while lane 1 holds a response.
    rsp_ready = 2'b00;
    single(1, mk(1, 0, 0, 0, 3'd4, 32'h0000_FFFF, 32'h00FF_00FF, 0, 32'h00FF_FF00, 0));
    cur[0] = mk(1, 0, 0, 0, 3'd0, 32'd1, 32'd1, 0, 32'd2, 0);
    req_valid[0] = 1'b1;
    neg();
    chk("rir_held", {30'd0, rsp_valid}, 32'b10);
    #2 rst = 1'b1;
    #1;
    chk("rir_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rir_rsp_result", rsp_result, 32'd0);
    chk("rir_req_ready", {30'd0, req_ready}, 32'd0);
    sbq.delete();
    pos();
    neg();
    chk("rir_no_accept", {30'd0, req_ready}, 32'd0);
    chk("rir_rsp_valid2", {30'd0, rsp_valid}, 32'd0);
    pos();
    req_valid = 2'b00;
    rst = 1'b0;
    rsp_ready = 2'b11;

    // Fairness after reset: 8 accepts, lane 0 first.
    for (int k = 0; k < 4; k++) begin
      for (int l = 0; l < 2; l++) begin
        a = $urandom; b = $urandom;
        if (k % 2 == 1) o = mk(1, 0, 0, 0, 3'd4, a, b, 0, a ^ b, 0);
        else            o = mk(1, 0, 0, 0, 3'd0, a, b, 0, a + b, 0);
        if (l == 0) cq0.push_back(o); else cq1.push_back(o);
      end
    end
    contend(8);
    neg();
    pos();
    neg();
    chk("sb_empty", sbq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/armleocpu_alu_arbiter.md
# armleocpu_alu_arbiter

- Shares one `armleocpu_alu` instance between two requesters (index 0 = execute stage, index 1 = auxiliary unit, e.g. CSR/address helper).
- Arbitrates round-robin over valid/ready request ports, drives the ALU from the granted request, and registers the result.
- Returns the registered result on a per-requester valid/ready response port.
- One operation in flight; result latency 1 cycle; full throughput when responses are consumed immediately.

## Interface
Parameters:
- none (two requesters, 32-bit data, fixed)

Ports (lane i of each vector belongs to requester i; lane 0 = bits [31:0] or bit 0):
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  2  request present, per requester
- req_ready  out  2  request accepted this cycle, per requester
- req_is_op  in  2  R-type ALU op
- req_is_op_imm  in  2  I-type ALU op
- req_shamt  in  10  5-bit shift amount per lane
- req_funct7  in  14  7-bit funct7 per lane
- req_funct3  in  6  3-bit funct3 per lane
- req_rs1  in  64  32-bit operand per lane
- req_rs2  in  64  32-bit operand per lane
- req_simm12  in  64  32-bit sign-extended immediate per lane
- rsp_valid  out  2  response present, per requester
- rsp_ready  in  2  response consumed, per requester
- rsp_result  out  32  registered ALU result (shared; qualified by rsp_valid)
- rsp_illegal  out  1  registered ALU illegal_instruction flag

## Operation
- States:
  - IDLE: no response held.
  - RESP: response held for requester `owner`.
- can_accept = (state==IDLE) or (state==RESP and rsp_valid[owner] and rsp_ready[owner]).
- Grant:
  - Only one requester valid: grant it.
  - Both valid: grant the requester not equal to `last_grant`.
  - req_ready[g] = can_accept and req_valid[g]; req_ready of the other lane = 0.
  - req_ready depends combinationally on req_valid and rsp_ready.
- ALU inputs are muxed combinationally from the granted lane; with no grant they select lane 0 (value irrelevant).
- On accept (req_valid[g] and req_ready[g]):
  - rsp_result <= ALU result; rsp_illegal <= ALU illegal_instruction.
  - owner <= g; last_grant <= g; state <= RESP.
- On response handshake with no new accept: state <= IDLE; rsp_result/rsp_illegal hold their last value.
- rsp_valid[i] = (state==RESP and owner==i).
- Requester rules:
  - Once req_valid is raised it is held, with stable fields, until req_ready.
  - rsp_ready may be asserted at any time.
  - rsp_ready on a lane that does not own the response is ignored.
- Illegal ops are not dropped. They complete normally with rsp_illegal=1 and result = rs1 + (is_op ? rs2 : simm12).
- Requests with req_is_op=req_is_op_imm=1 are outside the contract; result is whatever the ALU produces.

## Timing
- Reset values: state=IDLE, owner=0, last_grant=1 (requester 0 wins first tie), rsp_valid=2'b00, rsp_result=0, rsp_illegal=0.
- req_ready=0 while rst is asserted.
- Latency: request accepted at edge N -> rsp_valid high from after edge N through the edge where rsp_ready is seen.
- Back-to-back: response handshake and new accept at the same edge is allowed; rsp_valid stays continuously high (possibly switching lanes) and rsp_result updates at that edge. Throughput is 1 op/cycle.
- Backpressure: while RESP and rsp_ready[owner]=0:
  - req_ready=2'b00.
  - rsp_result/rsp_illegal/owner hold.
  - Pending requests wait; last_grant is not updated.
- Starvation-free: under continuous contention the grants alternate 0,1,0,1.
- Reset mid-operation: the held response is discarded without handshake, and all registers return to reset values asynchronously. Requests presented during reset are not accepted.
- No combinational path from rsp_result to any input; the only combinational outputs are req_ready.

## Test plan
- Single ADD on lane 0: rs1=5, rs2=7, is_op=1, funct3=0, funct7=0, rsp_ready=1 -> req_ready[0]=1 at cycle 0; rsp_valid=2'b01, rsp_result=12, rsp_illegal=0 at cycle 1.
- Tie after reset: both lanes valid with ADDI (lane 0 rs1=1, simm12=1; lane 1 rs1=10, simm12=-1), rsp_ready=2'b11 -> lane 0 granted first (result 2), lane 1 the next cycle (result 9); rsp_valid continuous for 2 cycles.
- Backpressure: lane 1 SRAI rs1=0x80000000, shamt=4, funct7=0x20, rsp_ready=0 for 3 cycles -> rsp_result=0xF8000000 held for 3 cycles, req_ready=0 on both lanes throughout; lane 0 request accepted on the cycle rsp_ready[1] rises.
- Illegal op: lane 0 is_op=1, funct3=0, funct7=0x01, rs1=3, rs2=4 -> rsp_illegal=1, rsp_result=7, handshake completes normally.
- Fairness: both lanes continuously valid for 8 accepts -> grant order 0,1,0,1,0,1,0,1, each response carries its lane's correct result.
- Reset in RESP: assert rst while rsp_valid=2'b10 -> rsp_valid=0, rsp_result=0 immediately (asynchronous); after release, next tie grants lane 0.
